uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Shares the single UART transmitter (9600 baud, 8N1, fed from the CLK_48M domain) between NUM_REQ byte-stream requesters, for example the RX echo path and the 7-segment/switch status reporter.
- Performs round-robin arbitration with packet locking. A packet ends on REQ_LAST, after MAX_BURST bytes, or after GAP_TIMEOUT idle cycles.
- Sequences the transmitter with a start/busy handshake so that only one byte is ever in flight.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- MAX_BURST, 16: maximum bytes per grant before the grant is forcibly released (1..255).
- GAP_TIMEOUT, 4096: CLK_48M cycles a granted requester may hold REQ_VALID low mid-packet before the grant is released (≥2).

Ports:
- CLK_48M  in  1  system clock, 48 MHz.
- RST  in  1  reset; synchronous, active-high.
- REQ_VALID  in  NUM_REQ  per-requester byte-available.
- REQ_DATA  in  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
- REQ_LAST  in  NUM_REQ  qualifies REQ_DATA as the final byte of a packet.
- REQ_READY  out  NUM_REQ  one-cycle pulse: byte taken from requester i.
- GRANT  out  NUM_REQ  one-hot current owner; all zero when idle.
- TX_START  out  1  one-cycle pulse to the transmitter.
- TX_DATA  out  8  byte for the transmitter; valid while TX_START=1 and held until the next TX_START.
- TX_BUSY  in  1  transmitter busy (start bit through stop bit).
- ACTIVE  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: one clock, CLK_48M. Reset is synchronous and active-high on RST. All outputs are registered.
- Reset values: GRANT=0, REQ_READY=0, TX_START=0, TX_DATA=8'h00, ACTIVE=0, state=IDLE, burst count=0, gap count=0, rr pointer=NUM_REQ-1 (so requester 0 wins first).
- Reset mid-transfer: aborts the packet immediately. The byte already started on the wire is not tracked. After reset the block stays in IDLE until TX_BUSY=0.
- IDLE:
  - If TX_BUSY=0 and any REQ_VALID is high, select the first valid requester searching upward from pointer+1 modulo NUM_REQ.
  - Next cycle: GRANT=onehot(g), burst=0, gap=0, go to SEND.
- SEND:
  - If REQ_VALID[g]=1 and TX_BUSY=0: next cycle TX_START=1, TX_DATA=REQ_DATA[g], REQ_READY[g]=1 (single cycle), last_flag=REQ_LAST[g], burst+=1, gap=0, go to WAIT_BUSY.
  - Requesters update REQ_DATA/REQ_LAST in the cycle after REQ_READY.
  - If REQ_VALID[g]=0: gap+=1. When gap reaches GAP_TIMEOUT-1, release and go to IDLE.
- WAIT_BUSY: wait for TX_BUSY=1, then go to WAIT_DONE. A transmitter that never raises busy hangs here; the transmitter guarantees busy within 2 cycles.
- WAIT_DONE: wait for TX_BUSY=0. Then:
  - if last_flag=1 or burst==MAX_BURST, release;
  - otherwise return to SEND.
- Release: GRANT=0, pointer=g, go to IDLE. The earliest re-arbitration is one cycle later, so another waiting requester wins over g.
- Simultaneous events:
  - REQ_LAST together with burst==MAX_BURST is a single release.
  - REQ_VALID for a non-granted requester is ignored; its REQ_READY stays 0.
- REQ_READY is never asserted to more than one requester. TX_START is never asserted while TX_BUSY=1 or in the cycle before TX_BUSY is seen to fall.
- Counters: burst is 8 bits, gap is clog2(GAP_TIMEOUT) bits, and neither wraps (release occurs first).

Decomposition:
- Package uart_sched_pkg:
  - state encoding IDLE/SEND/WAIT_BUSY/WAIT_DONE (2 bits);
  - constant BYTE_W=8;
  - function clog2.
- Sub-module rr_arbiter: combinational round-robin picker (valid vector + pointer -> one-hot + index). It is natural to split this out and reuse it for a later RX-side fan-out.

Test Plan:
(Bench: NUM_REQ=2, MAX_BURST=4, GAP_TIMEOUT=16; transmitter model raises TX_BUSY 1 cycle after TX_START and holds it 20 cycles.)
1. Reset → after RST, GRANT=00, ACTIVE=0, TX_START=0, TX_DATA=00.
2. Req0 sends 3 bytes 0x31,0x32,0x33 with LAST on 0x33 → exactly 3 TX_START pulses in order, 3 REQ_READY[0] pulses, then GRANT=00.
3. Both valid from idle; req0 has 2 bytes, req1 has 2 bytes (LAST on each second byte) → order 0,0,1,1. Then req0 valid again → granted after req1 releases.
4. Req1 streams 6 bytes, no LAST, req0 also valid → 4 bytes to req1, release, req0 granted, then req1 resumes with bytes 5–6.
5. Req0 sends 1 byte without LAST, then drops VALID → gap release after 16 cycles in SEND; GRANT=00; no extra TX_START.
6. RST asserted during WAIT_DONE with TX_BUSY=1 → next cycle all outputs at reset values; no TX_START until TX_BUSY=0 and a new REQ_VALID.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared state encoding, byte width and clog2 helper for the UART TX scheduler.
package uart_sched_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < v) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker; searches upward from ptr+1 modulo N.
module rr_arbiter
   import uart_sched_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = clog2(N)
) (
   input  logic [N-1:0]  valid,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);

   assign any = |valid;

   // Walk from farthest to nearest so the nearest valid requester wins last.
   always_comb begin
      onehot = '0;
      idx    = '0;
      for (int k = N; k >= 1; k--) begin
         if (valid[(int'(ptr) + k) % N]) begin
            onehot = N'(1) << ((int'(ptr) + k) % N);
            idx    = IW'((int'(ptr) + k) % N);
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin, packet-locked sharing of one UART transmitter.
// Only one byte is ever in flight, sequenced by the TX_START/TX_BUSY handshake.
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int MAX_BURST   = 16,
   parameter int GAP_TIMEOUT = 4096
) (
   input  logic                      CLK_48M,
   input  logic                      RST,
   input  logic [NUM_REQ-1:0]        REQ_VALID,
   input  logic [BYTE_W*NUM_REQ-1:0] REQ_DATA,
   input  logic [NUM_REQ-1:0]        REQ_LAST,
   output logic [NUM_REQ-1:0]        REQ_READY,
   output logic [NUM_REQ-1:0]        GRANT,
   output logic                      TX_START,
   output logic [BYTE_W-1:0]         TX_DATA,
   input  logic                      TX_BUSY,
   output logic                      ACTIVE
);

   localparam int IW = clog2(NUM_REQ);
   localparam int GW = clog2(GAP_TIMEOUT);

   state_e              state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [IW-1:0]       idx_q, idx_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [7:0]          burst_q, burst_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic                last_q, last_d;
   logic [NUM_REQ-1:0]  ready_q, ready_d;
   logic                start_q, start_d;
   logic [BYTE_W-1:0]   data_q, data_d;
   logic                active_q, active_d;
   logic                rel;
   logic [NUM_REQ-1:0]  arb_onehot;
   logic [IW-1:0]       arb_idx;
   logic                arb_any;

   rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
      .valid  (REQ_VALID),
      .ptr    (ptr_q),
      .onehot (arb_onehot),
      .idx    (arb_idx),
      .any    (arb_any)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      burst_d = burst_q;
      gap_d   = gap_q;
      last_d  = last_q;
      ready_d = '0;
      start_d = 1'b0;
      data_d  = data_q;
      rel     = 1'b0;
      case (state_q)
         IDLE: if (!TX_BUSY && arb_any) begin
            grant_d = arb_onehot;
            idx_d   = arb_idx;
            burst_d = '0;
            gap_d   = '0;
            state_d = SEND;
         end
         SEND: if (REQ_VALID[idx_q] && !TX_BUSY) begin
            start_d = 1'b1;
            data_d  = REQ_DATA[idx_q*BYTE_W +: BYTE_W];
            ready_d = grant_q;
            last_d  = REQ_LAST[idx_q];
            burst_d = burst_q + 8'd1;
            gap_d   = '0;
            state_d = WAIT_BUSY;
         end else if (!REQ_VALID[idx_q]) begin
            rel   = gap_q == GW'(GAP_TIMEOUT - 1);
            gap_d = rel ? gap_q : gap_q + 1'b1;
         end
         WAIT_BUSY: state_d = TX_BUSY ? WAIT_DONE : WAIT_BUSY;
         WAIT_DONE: if (!TX_BUSY) begin
            rel     = last_q || burst_q == 8'(MAX_BURST);
            state_d = SEND;
         end
         default: state_d = IDLE;
      endcase
      // Releasing hands the pointer to the owner so others win the next arbitration.
      if (rel) begin
         grant_d = '0;
         ptr_d   = idx_q;
         state_d = IDLE;
      end
      active_d = state_d != IDLE;
   end

   always_ff @(posedge CLK_48M) begin
      if (RST) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         idx_q    <= '0;
         ptr_q    <= IW'(NUM_REQ - 1);
         burst_q  <= '0;
         gap_q    <= '0;
         last_q   <= 1'b0;
         ready_q  <= '0;
         start_q  <= 1'b0;
         data_q   <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         idx_q    <= idx_d;
         ptr_q    <= ptr_d;
         burst_q  <= burst_d;
         gap_q    <= gap_d;
         last_q   <= last_d;
         ready_q  <= ready_d;
         start_q  <= start_d;
         data_q   <= data_d;
         active_q <= active_d;
      end
   end

   assign GRANT     = grant_q;
   assign REQ_READY = ready_q;
   assign TX_START  = start_q;
   assign TX_DATA   = data_q;
   assign ACTIVE    = active_q;

   assert property (@(posedge CLK_48M) disable iff (RST)
      $onehot0(REQ_READY) && ((REQ_READY & ~GRANT) == '0) && (TX_START == (REQ_READY != '0)));

endmodule
